// File: rtl/merlin_alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter: datapath width,
// ALU opcode encodings, requester ids and the response-slot state.
package merlin_alu_arbiter_pkg;

  localparam int RV_XLEN    = 32;
  localparam int RV_ALUOP_W = 4;

  typedef logic [RV_XLEN-1:0]    rv_word_t;
  typedef logic [RV_ALUOP_W-1:0] rv_aluop_t;

  localparam rv_aluop_t RV_ALUOP_ADD  = 4'd0;
  localparam rv_aluop_t RV_ALUOP_SUB  = 4'd1;
  localparam rv_aluop_t RV_ALUOP_AND  = 4'd2;
  localparam rv_aluop_t RV_ALUOP_OR   = 4'd3;
  localparam rv_aluop_t RV_ALUOP_XOR  = 4'd4;
  localparam rv_aluop_t RV_ALUOP_SLL  = 4'd5;
  localparam rv_aluop_t RV_ALUOP_SRL  = 4'd6;
  localparam rv_aluop_t RV_ALUOP_SRA  = 4'd7;
  localparam rv_aluop_t RV_ALUOP_SLT  = 4'd8;
  localparam rv_aluop_t RV_ALUOP_SLTU = 4'd9;
  localparam rv_aluop_t RV_ALUOP_MOV  = 4'd10;

  localparam logic RV_ALUARB_ID_REQ0 = 1'b0;
  localparam logic RV_ALUARB_ID_REQ1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic      clk_en;
    rv_aluop_t opcode;
    rv_word_t  left;
    rv_word_t  right;
  } alu_drive_t;

endpackage

// File: rtl/merlin_alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals. Signal suffixes are
// named from the arbiter's point of view (slave modport = arbiter).
interface merlin_alu_arbiter_if #(parameter int TAG_W = 4);
  import merlin_alu_arbiter_pkg::*;

  logic             req0_valid_i, req0_ready_o;
  rv_word_t         req0_left_i, req0_right_i;
  rv_aluop_t        req0_opcode_i;
  logic [TAG_W-1:0] req0_tag_i;

  logic             req1_valid_i, req1_ready_o;
  rv_word_t         req1_left_i, req1_right_i;
  rv_aluop_t        req1_opcode_i;
  logic [TAG_W-1:0] req1_tag_i;

  logic             alu_clk_en_o;
  rv_word_t         alu_left_o, alu_right_o, alu_cmp_left_o, alu_cmp_right_o;
  rv_aluop_t        alu_opcode_o;
  rv_word_t         alu_result_i;

  logic             rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [TAG_W-1:0] rsp_tag_o;
  rv_word_t         rsp_result_o;

  modport slave (
    input  req0_valid_i, req0_left_i, req0_right_i, req0_opcode_i, req0_tag_i,
    input  req1_valid_i, req1_left_i, req1_right_i, req1_opcode_i, req1_tag_i,
    input  alu_result_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o,
    output alu_clk_en_o, alu_left_o, alu_right_o, alu_cmp_left_o, alu_cmp_right_o, alu_opcode_o,
    output rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_result_o
  );

  modport master (
    output req0_valid_i, req0_left_i, req0_right_i, req0_opcode_i, req0_tag_i,
    output req1_valid_i, req1_left_i, req1_right_i, req1_opcode_i, req1_tag_i,
    output alu_result_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_clk_en_o, alu_left_o, alu_right_o, alu_cmp_left_o, alu_cmp_right_o, alu_opcode_o,
    input  rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_result_o
  );

endinterface

// File: rtl/merlin_arb2.sv
// Two-way arbiter. MERLIN_ALU_ARB_RR_EN defined: round-robin with a one-bit
// pointer; undefined: fixed priority with req0 always winning.
module merlin_arb2 (
`ifdef MERLIN_ALU_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] valid_i,
  input  logic       open_i,
  output logic [1:0] grant_o
);

  logic [1:0] req;
  assign req = valid_i & {2{open_i}};

`ifdef MERLIN_ALU_ARB_RR_EN
  // ptr_q == 0 favours req0, ptr_q == 1 favours req1 when both request.
  logic ptr_q, ptr_d;

  assign grant_o[0] = req[0] & ~(req[1] &  ptr_q);
  assign grant_o[1] = req[1] & ~(req[0] & ~ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (grant_o[0])      ptr_d = 1'b1;
    else if (grant_o[1]) ptr_d = 1'b0;
  end

  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign grant_o[0] = req[0];
  assign grant_o[1] = req[1] & ~req[0];
`endif

endmodule

// File: rtl/merlin_alu_arbiter.sv
// Shares one registered ALU between two requesters and holds a single-entry
// response slot. Arbitration policy selected by MERLIN_ALU_ARB_RR_EN.
module merlin_alu_arbiter
  import merlin_alu_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  merlin_alu_arbiter_if.slave bus
);

  slot_state_e      state_q, state_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             slot_open;
  logic [1:0]       grant;
  alu_drive_t       alu_drv;

  // Reset gates the slot so no grant (and no ALU clock enable) leaks out while held.
  assign slot_open = reset_n_i & ((state_q == ST_EMPTY) | bus.rsp_ready_i);

  merlin_arb2 u_arb (
`ifdef MERLIN_ALU_ARB_RR_EN
    .clk     (clk_i),
    .rst_n   (reset_n_i),
`endif
    .valid_i ({bus.req1_valid_i, bus.req0_valid_i}),
    .open_i  (slot_open),
    .grant_o (grant)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    alu_drv   = '{clk_en: 1'b0, opcode: RV_ALUOP_MOV, left: '0, right: '0};
    rsp_id_d  = rsp_id_q;
    rsp_tag_d = rsp_tag_q;
    state_d   = state_q;

    if (grant[0]) begin
      alu_drv   = '{clk_en: 1'b1, opcode: bus.req0_opcode_i,
                    left: bus.req0_left_i, right: bus.req0_right_i};
      rsp_id_d  = RV_ALUARB_ID_REQ0;
      rsp_tag_d = bus.req0_tag_i;
    end else if (grant[1]) begin
      alu_drv   = '{clk_en: 1'b1, opcode: bus.req1_opcode_i,
                    left: bus.req1_left_i, right: bus.req1_right_i};
      rsp_id_d  = RV_ALUARB_ID_REQ1;
      rsp_tag_d = bus.req1_tag_i;
    end

    case (state_q)
      ST_EMPTY: if (|grant) state_d = ST_FULL;
      ST_FULL: begin
        if (|grant)               state_d = ST_FULL;
        else if (bus.rsp_ready_i) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_EMPTY;
      rsp_id_q  <= RV_ALUARB_ID_REQ0;
      rsp_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      rsp_id_q  <= rsp_id_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  assign bus.req0_ready_o    = grant[0];
  assign bus.req1_ready_o    = grant[1];
  assign bus.alu_clk_en_o    = alu_drv.clk_en;
  assign bus.alu_opcode_o    = alu_drv.opcode;
  assign bus.alu_left_o      = alu_drv.left;
  assign bus.alu_right_o     = alu_drv.right;
  assign bus.alu_cmp_left_o  = alu_drv.left;
  assign bus.alu_cmp_right_o = alu_drv.right;
  assign bus.rsp_valid_o     = (state_q == ST_FULL);
  assign bus.rsp_id_o        = rsp_id_q;
  assign bus.rsp_tag_o       = rsp_tag_q;
  assign bus.rsp_result_o    = bus.alu_result_i;

endmodule

// File: tb/tb_merlin_alu_arbiter.sv
// Directed bench for merlin_alu_arbiter with a registered-ALU model on the
// shared ALU port. Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_merlin_alu_arbiter;
  import merlin_alu_arbiter_pkg::*;

  localparam int TAG_W = 4;
`ifdef MERLIN_ALU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  merlin_alu_arbiter_if #(.TAG_W(TAG_W)) bus ();

  merlin_alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  function automatic rv_word_t alu_f(input rv_aluop_t op, input rv_word_t l, input rv_word_t r);
    case (op)
      RV_ALUOP_ADD:  return l + r;
      RV_ALUOP_SUB:  return l - r;
      RV_ALUOP_AND:  return l & r;
      RV_ALUOP_OR:   return l | r;
      RV_ALUOP_XOR:  return l ^ r;
      RV_ALUOP_SLT:  return {31'b0, $signed(l) < $signed(r)};
      RV_ALUOP_SLTU: return {31'b0, l < r};
      RV_ALUOP_MOV:  return r;
      default:       return '0;
    endcase
  endfunction

  // Shared ALU result register, loaded only when the arbiter enables it.
  always @(posedge clk)
    if (bus.alu_clk_en_o)
      bus.alu_result_i <= alu_f(bus.alu_opcode_o, bus.alu_cmp_left_o, bus.alu_cmp_right_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_reqs();
    bus.req0_valid_i = 1'b0; bus.req0_left_i = '0; bus.req0_right_i = '0;
    bus.req0_opcode_i = RV_ALUOP_ADD; bus.req0_tag_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_left_i = '0; bus.req1_right_i = '0;
    bus.req1_opcode_i = RV_ALUOP_ADD; bus.req1_tag_i = '0;
  endtask

  task automatic drive_req(input int n, input rv_aluop_t op, input rv_word_t l,
                           input rv_word_t r, input logic [TAG_W-1:0] tag);
    if (n == 0) begin
      bus.req0_valid_i = 1'b1; bus.req0_opcode_i = op;
      bus.req0_left_i = l; bus.req0_right_i = r; bus.req0_tag_i = tag;
    end else begin
      bus.req1_valid_i = 1'b1; bus.req1_opcode_i = op;
      bus.req1_left_i = l; bus.req1_right_i = r; bus.req1_tag_i = tag;
    end
  endtask

  // Short reset pulse inside the low clock phase; no rising edge sees it.
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    idle_reqs();
    bus.rsp_ready_i = 1'b1;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int       exp_g, prev_g;
    rv_word_t base [2];
    base[0] = 32'd10;
    base[1] = 32'd20;
    prev_g  = 0;

    // Held in reset with both requesters valid: nothing may be granted.
    rst_n = 1'b0;
    idle_reqs();
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    bus.rsp_ready_i  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0",  32'(bus.req0_ready_o), 32'd0);
    check("rst_ready1",  32'(bus.req1_ready_o), 32'd0);
    check("rst_clk_en",  32'(bus.alu_clk_en_o), 32'd0);
    check("rst_rsp_vld", 32'(bus.rsp_valid_o),  32'd0);
    check("rst_opcode",  32'(bus.alu_opcode_o), 32'(RV_ALUOP_MOV));

    // First cycle after release: ADD 5+7 tag 3 on req0.
    @(negedge clk);
    rst_n = 1'b1;
    idle_reqs();
    drive_req(0, RV_ALUOP_ADD, 32'd5, 32'd7, 4'd3);
    #1;
    check("add_ready0", 32'(bus.req0_ready_o), 32'd1);
    check("add_clk_en", 32'(bus.alu_clk_en_o), 32'd1);
    check("add_left",   bus.alu_left_o,        32'd5);
    check("add_right",  bus.alu_right_o,       32'd7);
    @(negedge clk);
    idle_reqs();
    #1;
    check("add_rsp_vld",  32'(bus.rsp_valid_o),  32'd1);
    check("add_result",   bus.rsp_result_o,      32'd12);
    check("add_id",       32'(bus.rsp_id_o),     32'd0);
    check("add_tag",      32'(bus.rsp_tag_o),    32'd3);
    check("idle_clk_en",  32'(bus.alu_clk_en_o), 32'd0);
    check("idle_left",    bus.alu_left_o,        32'd0);
    check("idle_cmp_rgt", bus.alu_cmp_right_o,   32'd0);
    check("idle_opcode",  32'(bus.alu_opcode_o), 32'(RV_ALUOP_MOV));
    @(negedge clk);
    #1;
    check("drain_rsp_vld", 32'(bus.rsp_valid_o), 32'd0);

    // Both valid every cycle: alternating under round-robin, req0 only otherwise.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_req(0, RV_ALUOP_ADD, base[0], 32'(i), 4'd1);
      drive_req(1, RV_ALUOP_ADD, base[1], 32'(i), 4'd2);
      #1;
      exp_g = RR_EN ? (i % 2) : 0;
      check("both_ready0", 32'(bus.req0_ready_o), 32'(exp_g == 0));
      check("both_ready1", 32'(bus.req1_ready_o), 32'(exp_g == 1));
      if (i > 0) begin
        check("both_rsp_vld", 32'(bus.rsp_valid_o), 32'd1);
        check("both_id",      32'(bus.rsp_id_o),    32'(prev_g));
        check("both_tag",     32'(bus.rsp_tag_o),   32'(prev_g + 1));
        check("both_result",  bus.rsp_result_o,     base[prev_g] + 32'(i - 1));
      end
      prev_g = exp_g;
    end
    @(negedge clk);
    idle_reqs();
    #1;
    check("both_last_id",  32'(bus.rsp_id_o), 32'(prev_g));
    check("both_last_res", bus.rsp_result_o,  base[prev_g] + 32'd3);

    // Backpressure: SUB 0-1 held for three stalled cycles.
    reset_pulse();
    @(negedge clk);
    drive_req(0, RV_ALUOP_SUB, 32'd0, 32'd1, 4'd5);
    #1;
    check("bp_grant", 32'(bus.req0_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      drive_req(0, RV_ALUOP_ADD, 32'd1, 32'd1, 4'd6);
      drive_req(1, RV_ALUOP_ADD, 32'd2, 32'd2, 4'd7);
      #1;
      check("bp_rsp_vld", 32'(bus.rsp_valid_o),  32'd1);
      check("bp_result",  bus.rsp_result_o,      32'hFFFF_FFFF);
      check("bp_id",      32'(bus.rsp_id_o),     32'd0);
      check("bp_tag",     32'(bus.rsp_tag_o),    32'd5);
      check("bp_clk_en",  32'(bus.alu_clk_en_o), 32'd0);
      check("bp_ready0",  32'(bus.req0_ready_o), 32'd0);
      check("bp_ready1",  32'(bus.req1_ready_o), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready_i  = 1'b1;
    bus.req1_valid_i = 1'b0;
    #1;
    check("rel_ready0", 32'(bus.req0_ready_o), 32'd1);
    check("rel_clk_en", 32'(bus.alu_clk_en_o), 32'd1);
    check("rel_old_res", bus.rsp_result_o,     32'hFFFF_FFFF);
    @(negedge clk);
    idle_reqs();
    #1;
    check("rel_result", bus.rsp_result_o,   32'd2);
    check("rel_tag",    32'(bus.rsp_tag_o), 32'd6);

    // SLT from req1 alone: signed compare of 0x80000000 against 1.
    @(negedge clk);
    drive_req(1, RV_ALUOP_SLT, 32'h8000_0000, 32'd1, 4'd9);
    #1;
    check("slt_ready1",   32'(bus.req1_ready_o), 32'd1);
    check("slt_ready0",   32'(bus.req0_ready_o), 32'd0);
    check("slt_cmp_left", bus.alu_cmp_left_o,    32'h8000_0000);
    check("slt_cmp_rgt",  bus.alu_cmp_right_o,   32'd1);
    check("slt_opcode",   32'(bus.alu_opcode_o), 32'(RV_ALUOP_SLT));
    @(negedge clk);
    idle_reqs();
    #1;
    check("slt_result", bus.rsp_result_o,   32'd1);
    check("slt_id",     32'(bus.rsp_id_o),  32'd1);
    check("slt_tag",    32'(bus.rsp_tag_o), 32'd9);

    // Reset while FULL drops the response at once and produces none afterwards.
    @(negedge clk);
    drive_req(0, RV_ALUOP_ADD, 32'd3, 32'd4, 4'hA);
    #1;
    @(negedge clk);
    idle_reqs();
    bus.rsp_ready_i = 1'b0;
    #1;
    check("pre_rst_vld", 32'(bus.rsp_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(bus.rsp_valid_o), 32'd0);
    check("mid_rst_tag", 32'(bus.rsp_tag_o),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_vld", 32'(bus.rsp_valid_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
